// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package ifetch_pkg;

  localparam logic [31:0] ResetPcDefault = 32'h1c00_0000;

  // Position of the fetch-address exception in the except_type vector.
  localparam int unsigned ExcAdefIdx = 0;

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StFull
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } br_upd_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Bundle of instruction-bus, decode-handshake, redirect and branch-update signals for inst_fetch.
interface inst_fetch_if;

  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_branch;
  logic [31:0] if_branch_addr;
  logic        if_adef;

  logic        redirect_en;
  logic [31:0] redirect_pc;

  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  id_ready,
    output if_valid, if_pc, if_inst, if_branch, if_branch_addr, if_adef,
    input  redirect_en, redirect_pc,
    input  upd_en, upd_pc, upd_taken, upd_target
  );

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output id_ready,
    input  if_valid, if_pc, if_inst, if_branch, if_branch_addr, if_adef,
    output redirect_en, redirect_pc,
    output upd_en, upd_pc, upd_taken, upd_target
  );

endinterface

// File: rtl/ifetch_btb.sv
// Direct-mapped branch target buffer with 2-bit counters; used by inst_fetch under IFETCH_BTB_EN.
module ifetch_btb
  import ifetch_pkg::*;
#(
  parameter int unsigned Entries = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] lookup_pc_i,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        upd_en_i,
  input  br_upd_t     upd_i
);

  localparam int unsigned IdxW = $clog2(Entries);
  localparam int unsigned TagW = 30 - IdxW;

  logic [Entries-1:0] valid_q;
  logic [TagW-1:0]    tag_q    [Entries];
  logic [31:0]        target_q [Entries];
  logic [1:0]         cnt_q    [Entries];

  logic [IdxW-1:0] rd_idx, wr_idx;
  logic [TagW-1:0] rd_tag, wr_tag;
  logic            wr_hit;
  logic [1:0]      cnt_d;

  assign rd_idx = lookup_pc_i[IdxW+1:2];
  assign rd_tag = lookup_pc_i[31:IdxW+2];
  assign wr_idx = upd_i.pc[IdxW+1:2];
  assign wr_tag = upd_i.pc[31:IdxW+2];
  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  // Counter >= 2 means predict taken, i.e. the MSB.
  assign pred_taken_o  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag) && cnt_q[rd_idx][1];
  assign pred_target_o = target_q[rd_idx];

  always_comb begin
    cnt_d = cnt_q[wr_idx];
    if (!wr_hit) begin
      cnt_d = upd_i.taken ? 2'd2 : 2'd1;
    end else if (upd_i.taken && (cnt_q[wr_idx] != 2'd3)) begin
      cnt_d = cnt_q[wr_idx] + 2'd1;
    end else if (!upd_i.taken && (cnt_q[wr_idx] != 2'd0)) begin
      cnt_d = cnt_q[wr_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (upd_en_i) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (upd_en_i) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= upd_i.target;
      cnt_q[wr_idx]    <= cnt_d;
    end
  end

  logic unused_lo;
  assign unused_lo = ^{lookup_pc_i[1:0], upd_i.pc[1:0]};

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: PC, single-outstanding bus request, one output slot for decode.
// Optional BTB prediction is enabled by defining IFETCH_BTB_EN.
module inst_fetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = ResetPcDefault,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input logic          clk,
  input logic          rst,
  inst_fetch_if.master fetch_if
);

  fetch_state_e state_q;
  logic [31:0]  pc_q, req_pc_q, req_target_q;
  logic         req_branch_q, cancel_q;
  logic         valid_q, adef_q, branch_q;
  logic [31:0]  out_pc_q, inst_q, branch_addr_q;

  logic        pred_taken;
  logic [31:0] pred_target, pc_seq;
  logic        misaligned, slot_free, drain, req_fire;

  assign pc_seq     = pc_q + 32'd4;
  assign misaligned = pc_q[1:0] != 2'b00;
  assign drain      = valid_q & fetch_if.id_ready;
  assign slot_free  = ~valid_q | fetch_if.id_ready;

  // Request only when the returning word will have a free slot to land in.
  assign fetch_if.inst_req  = ~rst & (state_q == StReq) & ~misaligned & slot_free;
  assign fetch_if.inst_addr = pc_q;
  assign req_fire           = fetch_if.inst_req & fetch_if.inst_addr_ok;

`ifdef IFETCH_BTB_EN
  br_upd_t     upd;
  logic [31:0] btb_target;

  assign upd = '{pc: fetch_if.upd_pc, taken: fetch_if.upd_taken, target: fetch_if.upd_target};

  ifetch_btb #(
    .Entries(BTB_ENTRIES)
  ) u_btb (
    .clk_i        (clk),
    .rst_i        (rst),
    .lookup_pc_i  (pc_q),
    .pred_taken_o (pred_taken),
    .pred_target_o(btb_target),
    .upd_en_i     (fetch_if.upd_en),
    .upd_i        (upd)
  );

  assign pred_target = pred_taken ? btb_target : pc_seq;
`else
  assign pred_taken  = 1'b0;
  assign pred_target = pc_seq;

  logic unused_upd;
  assign unused_upd = ^{fetch_if.upd_en, fetch_if.upd_pc, fetch_if.upd_taken,
                        fetch_if.upd_target, BTB_ENTRIES};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StReq;
      pc_q          <= RESET_PC;
      cancel_q      <= 1'b0;
      req_pc_q      <= '0;
      req_branch_q  <= 1'b0;
      req_target_q  <= '0;
      valid_q       <= 1'b0;
      adef_q        <= 1'b0;
      branch_q      <= 1'b0;
      out_pc_q      <= '0;
      inst_q        <= '0;
      branch_addr_q <= '0;
    end else if (fetch_if.redirect_en) begin
      pc_q    <= fetch_if.redirect_pc;
      valid_q <= 1'b0;
      adef_q  <= 1'b0;
      // A response still owed by the bus must be swallowed before the next request.
      if (((state_q == StWait) && !fetch_if.inst_data_ok) || req_fire) begin
        cancel_q <= 1'b1;
        state_q  <= StWait;
      end else begin
        cancel_q <= 1'b0;
        state_q  <= StReq;
      end
    end else begin
      if (drain) valid_q <= 1'b0;
      case (state_q)
        StReq: begin
          if (!slot_free) begin
            state_q <= StFull;
          end else if (misaligned) begin
            valid_q       <= 1'b1;
            adef_q        <= 1'b1;
            out_pc_q      <= pc_q;
            inst_q        <= '0;
            branch_q      <= 1'b0;
            branch_addr_q <= pc_seq;
            state_q       <= StFull;
          end else if (req_fire) begin
            req_pc_q     <= pc_q;
            req_branch_q <= pred_taken;
            req_target_q <= pred_target;
            pc_q         <= pred_target;
            state_q      <= StWait;
          end
        end
        StWait: begin
          if (fetch_if.inst_data_ok) begin
            if (cancel_q) begin
              cancel_q <= 1'b0;
              state_q  <= StReq;
            end else begin
              valid_q       <= 1'b1;
              adef_q        <= 1'b0;
              out_pc_q      <= req_pc_q;
              inst_q        <= fetch_if.inst_rdata;
              branch_q      <= req_branch_q;
              branch_addr_q <= req_target_q;
              state_q       <= fetch_if.id_ready ? StReq : StFull;
            end
          end
        end
        StFull: begin
          if (drain) state_q <= StReq;
        end
        default: state_q <= StReq;
      endcase
    end
  end

  assign fetch_if.if_valid       = valid_q;
  assign fetch_if.if_pc          = out_pc_q;
  assign fetch_if.if_inst        = inst_q;
  assign fetch_if.if_branch      = branch_q;
  assign fetch_if.if_branch_addr = branch_addr_q;
  assign fetch_if.if_adef        = adef_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: bus responder, slot monitor and per-scenario tasks.
module tb_inst_fetch;
  import ifetch_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        br;
    logic [31:0] baddr;
    logic        adef;
    logic [31:0] cyc;
  } slot_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_fetch_if bif ();

  inst_fetch #(
    .RESET_PC   (32'h1c00_0000),
    .BTB_ENTRIES(16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .fetch_if(bif)
  );

  slot_t       out_log[$];
  slot_t       exp_q[$];
  logic [31:0] req_log[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int data_delay = 0;
  int proto_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hbeef, a[31:16]};
  endfunction

  // Bus responder and consumed-slot monitor, both evaluated at the falling edge.
  initial begin
    logic        pend;
    logic [31:0] pend_addr;
    int          pend_cnt;
    pend = 1'b0;
    pend_addr = '0;
    pend_cnt = 0;
    bif.inst_addr_ok = 1'b0;
    bif.inst_data_ok = 1'b0;
    bif.inst_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst && bif.if_valid && bif.id_ready && !bif.redirect_en)
        out_log.push_back('{pc: bif.if_pc, inst: bif.if_inst, br: bif.if_branch,
                            baddr: bif.if_branch_addr, adef: bif.if_adef, cyc: 32'(cyc)});
      if (!rst && bif.inst_req && pend) proto_err++;
      bif.inst_addr_ok = 1'b0;
      bif.inst_data_ok = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (pend_cnt == 0) begin
            bif.inst_data_ok = 1'b1;
            bif.inst_rdata = mem_word(pend_addr);
            pend = 1'b0;
          end else begin
            pend_cnt--;
          end
        end
        if (bif.inst_req) begin
          bif.inst_addr_ok = 1'b1;
          req_log.push_back(bif.inst_addr);
          pend = 1'b1;
          pend_addr = bif.inst_addr;
          pend_cnt = data_delay;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    bif.id_ready = 1'b0;
    bif.redirect_en = 1'b0;
    bif.redirect_pc = '0;
    bif.upd_en = 1'b0;
    bif.upd_pc = '0;
    bif.upd_taken = 1'b0;
    bif.upd_target = '0;
    data_delay = 0;
    repeat (3) @(posedge clk);
    #1;
    req_log.delete();
    out_log.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bif.inst_req !== 1'b0) begin errors++;
      $display("FAIL reset_inst_req got %b want 0", bif.inst_req); end
    checks++; if (bif.if_valid !== 1'b0) begin errors++;
      $display("FAIL reset_if_valid got %b want 0", bif.if_valid); end
    checks++; if (bif.if_adef !== 1'b0) begin errors++;
      $display("FAIL reset_if_adef got %b want 0", bif.if_adef); end
    checks++; if (bif.if_branch !== 1'b0) begin errors++;
      $display("FAIL reset_if_branch got %b want 0", bif.if_branch); end
    checks++; if (bif.if_pc !== 32'h0) begin errors++;
      $display("FAIL reset_if_pc got %h want 0", bif.if_pc); end
    checks++; if (bif.if_inst !== 32'h0) begin errors++;
      $display("FAIL reset_if_inst got %h want 0", bif.if_inst); end
    checks++; if (bif.if_branch_addr !== 32'h0) begin errors++;
      $display("FAIL reset_if_branch_addr got %h want 0", bif.if_branch_addr); end
  endtask

  task automatic test_stream();
    slot_t got, exp;
    logic [31:0] p;
    do_reset();
    bif.id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      p = 32'h1c00_0000 + 32'(4 * i);
      exp_q.push_back('{pc: p, inst: mem_word(p), br: 1'b0, baddr: p + 32'd4, adef: 1'b0, cyc: 0});
    end
    rst = 1'b0;
    for (int n = 0; n < 40 && out_log.size() < 3; n++) @(posedge clk);
    #1;
    checks++; if (out_log.size() < 3) begin errors++;
      $display("FAIL stream_count got %0d slots want 3", out_log.size()); end
    for (int i = 0; i < 3 && i < req_log.size(); i++) begin
      checks++;
      if (req_log[i] !== 32'h1c00_0000 + 32'(4 * i)) begin errors++;
        $display("FAIL stream_req%0d got %h want %h", i, req_log[i], 32'h1c00_0000 + 32'(4 * i));
      end
    end
    if (out_log.size() >= 3) begin
      checks++;
      if (out_log[1].cyc - out_log[0].cyc != 2 || out_log[2].cyc - out_log[1].cyc != 2) begin
        errors++;
        $display("FAIL stream_spacing got %0d,%0d want 2,2", out_log[1].cyc - out_log[0].cyc,
                 out_log[2].cyc - out_log[1].cyc);
      end
    end
    while (exp_q.size() > 0 && out_log.size() > 0) begin
      exp = exp_q.pop_front();
      got = out_log.pop_front();
      checks++;
      if (got.pc !== exp.pc || got.inst !== exp.inst || got.br !== exp.br ||
          got.baddr !== exp.baddr || got.adef !== exp.adef) begin
        errors++;
        $display("FAIL stream_slot got pc=%h inst=%h br=%b ba=%h adef=%b want pc=%h inst=%h br=%b ba=%h adef=%b",
                 got.pc, got.inst, got.br, got.baddr, got.adef,
                 exp.pc, exp.inst, exp.br, exp.baddr, exp.adef);
      end
    end
  endtask

  task automatic test_backpressure();
    int nreq;
    do_reset();
    rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (bif.if_valid) break;
    end
    checks++; if (bif.if_valid !== 1'b1 || bif.if_pc !== 32'h1c00_0000 ||
                  bif.if_inst !== mem_word(32'h1c00_0000)) begin errors++;
      $display("FAIL bp_fill got valid=%b pc=%h inst=%h want 1 1c000000 %h",
               bif.if_valid, bif.if_pc, bif.if_inst, mem_word(32'h1c00_0000)); end
    nreq = req_log.size();
    repeat (5) begin
      @(posedge clk); #1;
      checks++;
      if (bif.if_valid !== 1'b1 || bif.if_pc !== 32'h1c00_0000 ||
          bif.if_inst !== mem_word(32'h1c00_0000) || bif.inst_req !== 1'b0) begin errors++;
        $display("FAIL bp_hold got valid=%b pc=%h inst=%h req=%b want 1 1c000000 %h 0",
                 bif.if_valid, bif.if_pc, bif.if_inst, bif.inst_req, mem_word(32'h1c00_0000));
      end
    end
    checks++; if (req_log.size() != nreq) begin errors++;
      $display("FAIL bp_noreq got %0d requests want %0d", req_log.size(), nreq); end
    bif.id_ready = 1'b1;
    for (int n = 0; n < 20 && req_log.size() <= nreq; n++) begin @(posedge clk); #1; end
    checks++; if (req_log.size() <= nreq || req_log[nreq] !== 32'h1c00_0004) begin errors++;
      $display("FAIL bp_next_req got %h want 1c000004",
               req_log.size() > nreq ? req_log[nreq] : 32'hxxxx_xxxx); end
  endtask

  task automatic test_redirect_wait();
    slot_t got, exp;
    do_reset();
    data_delay = 3;
    bif.id_ready = 1'b1;
    exp_q.push_back('{pc: 32'h1c00_0100, inst: mem_word(32'h1c00_0100), br: 1'b0,
                      baddr: 32'h1c00_0104, adef: 1'b0, cyc: 0});
    exp_q.push_back('{pc: 32'h1c00_0104, inst: mem_word(32'h1c00_0104), br: 1'b0,
                      baddr: 32'h1c00_0108, adef: 1'b0, cyc: 0});
    rst = 1'b0;
    for (int n = 0; n < 20 && req_log.size() < 1; n++) begin @(posedge clk); #1; end
    bif.redirect_pc = 32'h1c00_0100;
    bif.redirect_en = 1'b1;
    @(posedge clk); #1;
    bif.redirect_en = 1'b0;
    for (int n = 0; n < 60 && out_log.size() < 2; n++) begin @(posedge clk); #1; end
    checks++; if (out_log.size() < 2) begin errors++;
      $display("FAIL rw_count got %0d slots want 2", out_log.size()); end
    checks++; if (req_log.size() < 2 || req_log[1] !== 32'h1c00_0100) begin errors++;
      $display("FAIL rw_next_req got %h want 1c000100",
               req_log.size() > 1 ? req_log[1] : 32'hxxxx_xxxx); end
    checks++; if (proto_err != 0) begin errors++;
      $display("FAIL rw_outstanding got %0d overlapping requests want 0", proto_err); end
    while (exp_q.size() > 0 && out_log.size() > 0) begin
      exp = exp_q.pop_front();
      got = out_log.pop_front();
      checks++;
      if (got.pc !== exp.pc || got.inst !== exp.inst || got.br !== exp.br ||
          got.baddr !== exp.baddr) begin
        errors++;
        $display("FAIL rw_slot got pc=%h inst=%h br=%b ba=%h want pc=%h inst=%h br=%b ba=%h",
                 got.pc, got.inst, got.br, got.baddr, exp.pc, exp.inst, exp.br, exp.baddr);
      end
    end
  endtask

  task automatic test_adef();
    int nreq;
    do_reset();
    rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (bif.if_valid) break;
    end
    nreq = req_log.size();
    bif.redirect_pc = 32'h1c00_0102;
    bif.redirect_en = 1'b1;
    @(posedge clk); #1;
    bif.redirect_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_log.size() != nreq || bif.inst_req !== 1'b0) begin errors++;
      $display("FAIL adef_noreq got %0d requests req=%b want %0d 0",
               req_log.size(), bif.inst_req, nreq); end
    checks++; if (bif.if_valid !== 1'b1 || bif.if_adef !== 1'b1) begin errors++;
      $display("FAIL adef_flag got valid=%b adef=%b want 1 1", bif.if_valid, bif.if_adef); end
    checks++; if (bif.if_pc !== 32'h1c00_0102 || bif.if_inst !== 32'h0) begin errors++;
      $display("FAIL adef_slot got pc=%h inst=%h want 1c000102 0", bif.if_pc, bif.if_inst); end
  endtask

  task automatic test_branch_predict();
    slot_t got, exp;
    int nreq;
    logic        exp_br;
    logic [31:0] exp_next;
`ifdef IFETCH_BTB_EN
    exp_br = 1'b1;
    exp_next = 32'h1c00_0040;
`else
    exp_br = 1'b0;
    exp_next = 32'h1c00_0014;
`endif
    do_reset();
    rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (bif.if_valid) break;
    end
    bif.upd_pc = 32'h1c00_0010;
    bif.upd_taken = 1'b1;
    bif.upd_target = 32'h1c00_0040;
    bif.upd_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bif.upd_en = 1'b0;
    nreq = req_log.size();
    exp_q.push_back('{pc: 32'h1c00_0010, inst: mem_word(32'h1c00_0010), br: exp_br,
                      baddr: exp_next, adef: 1'b0, cyc: 0});
    bif.redirect_pc = 32'h1c00_0010;
    bif.redirect_en = 1'b1;
    bif.id_ready = 1'b1;
    @(posedge clk); #1;
    bif.redirect_en = 1'b0;
    for (int n = 0; n < 30 && (out_log.size() < 1 || req_log.size() < nreq + 2); n++) begin
      @(posedge clk); #1;
    end
    checks++; if (req_log.size() < nreq + 2 || req_log[nreq] !== 32'h1c00_0010 ||
                  req_log[nreq+1] !== exp_next) begin errors++;
      $display("FAIL bp_reqs got %0d new requests, want 1c000010 then %h",
               req_log.size() - nreq, exp_next); end
    checks++; if (out_log.size() < 1) begin errors++;
      $display("FAIL bp_slot_count got 0 slots want 1"); end
    if (exp_q.size() > 0 && out_log.size() > 0) begin
      exp = exp_q.pop_front();
      got = out_log.pop_front();
      checks++;
      if (got.pc !== exp.pc || got.inst !== exp.inst || got.br !== exp.br ||
          got.baddr !== exp.baddr) begin
        errors++;
        $display("FAIL bp_slot got pc=%h inst=%h br=%b ba=%h want pc=%h inst=%h br=%b ba=%h",
                 got.pc, got.inst, got.br, got.baddr, exp.pc, exp.inst, exp.br, exp.baddr);
      end
    end
  endtask

  task automatic test_redirect_data_ok();
    slot_t got, exp;
    int nreq;
    logic got_dok;
    do_reset();
    data_delay = 1;
    bif.id_ready = 1'b1;
    exp_q.push_back('{pc: 32'h1c00_0200, inst: mem_word(32'h1c00_0200), br: 1'b0,
                      baddr: 32'h1c00_0204, adef: 1'b0, cyc: 0});
    rst = 1'b0;
    got_dok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk); #1;
      if (bif.inst_data_ok) begin
        got_dok = 1'b1;
        break;
      end
    end
    checks++; if (!got_dok) begin errors++;
      $display("FAIL rd_data_ok got 0 want 1"); end
    nreq = req_log.size();
    bif.redirect_pc = 32'h1c00_0200;
    bif.redirect_en = 1'b1;
    @(posedge clk); #1;
    bif.redirect_en = 1'b0;
    checks++; if (bif.if_valid !== 1'b0) begin errors++;
      $display("FAIL rd_invalidate got valid=%b want 0", bif.if_valid); end
    for (int n = 0; n < 30 && (out_log.size() < 1 || req_log.size() <= nreq); n++) begin
      @(posedge clk); #1;
    end
    checks++; if (req_log.size() <= nreq || req_log[nreq] !== 32'h1c00_0200) begin errors++;
      $display("FAIL rd_next_req got %h want 1c000200",
               req_log.size() > nreq ? req_log[nreq] : 32'hxxxx_xxxx); end
    checks++; if (out_log.size() < 1) begin errors++;
      $display("FAIL rd_slot_count got 0 slots want 1"); end
    if (exp_q.size() > 0 && out_log.size() > 0) begin
      exp = exp_q.pop_front();
      got = out_log.pop_front();
      checks++;
      if (got.pc !== exp.pc || got.inst !== exp.inst) begin
        errors++;
        $display("FAIL rd_slot got pc=%h inst=%h want pc=%h inst=%h",
                 got.pc, got.inst, exp.pc, exp.inst);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_adef();
    test_branch_predict();
    test_redirect_data_ok();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Owns the PC register and issues one outstanding request at a time on the SRAM-like instruction bus (req/addr_ok/data_ok).
- Presents {pc, inst, predicted branch, predicted target} to decode with a valid/ready handshake.
- Redirects on decode's predict_miss, using the corrected target from branch_info; flags misaligned fetch (ADEF) without issuing a bus request.

Parameters:
RESET_PC, 32'h1c00_0000, PC value loaded on reset
BTB_ENTRIES, 16, BTB depth (power of 2; used only with IFETCH_BTB_EN)

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
inst_req  output  1  bus request valid
inst_addr  output  32  bus request address
inst_addr_ok  input  1  request accepted this cycle
inst_data_ok  input  1  read data returned this cycle
inst_rdata  input  32  read data
id_ready  input  1  decode accepts the output this cycle
if_valid  output  1  output slot holds a valid instruction
if_pc  output  32  PC of the output instruction
if_inst  output  32  instruction word
if_branch  output  1  predicted taken
if_branch_addr  output  32  predicted target (pc+4 when not taken)
if_adef  output  1  fetch-address exception for this slot
redirect_en  input  1  decode predict_miss
redirect_pc  input  32  corrected next PC (taken ? target : pc+4)
upd_en  input  1  resolved branch/jump update (branch_flag)
upd_pc  input  32  PC of the resolved branch
upd_taken  input  1  resolved direction
upd_target  input  32  resolved target

Behaviour:
- Reset:
  - pc = RESET_PC; state = REQ.
  - Outputs: inst_req = 0, if_valid = 0, if_adef = 0, if_branch = 0, if_pc / if_inst / if_branch_addr = 0.
  - Cancel counter = 0; BTB valid bits cleared.
- FSM states: REQ, WAIT, FULL.
- REQ:
  - If pc[1:0] != 0: no request is issued. Load the output slot with if_adef = 1, if_inst = 0, if_valid = 1, then go to FULL.
  - Otherwise drive inst_req = 1 with inst_addr = pc.
  - On inst_addr_ok, latch the request PC and prediction, and go to WAIT.
- WAIT:
  - On inst_data_ok with cancel = 0, load the output slot (if_valid = 1).
  - Next state is REQ if id_ready is already high for a slot being drained, otherwise FULL.
  - Latency: the instruction is visible the cycle after data_ok. This gives a 2-cycle minimum addr_ok-to-output with a zero-wait bus.
- FULL: hold the slot stable until if_valid & id_ready. The slot is consumed that cycle and the FSM goes to REQ.
- Next-PC rule: on each accepted request, pc = pred_taken ? pred_target : pc + 4 (32-bit wrap-around allowed).
- Handshake:
  - Once asserted, inst_req and inst_addr stay stable until addr_ok.
  - Never more than one request is outstanding.
  - A slot is consumed only on if_valid & id_ready.
- Redirect (highest priority after rst):
  - pc = redirect_pc.
  - Output slot invalidated the same edge.
  - If in WAIT, or if addr_ok occurs in the redirect cycle, set cancel = 1 and stay in WAIT. The next data_ok is discarded and clears cancel, then the FSM goes to REQ.
  - Redirect while in REQ (no addr_ok): the next request uses redirect_pc.
- Simultaneous events:
  - redirect_en & id_ready in the same cycle: redirect wins and the slot is invalidated.
  - data_ok and redirect in the same cycle: the data is dropped.
- Reset mid-transaction: state and pc reinitialise. A stale data_ok arriving after reset is ignored: the bus guarantees no response after rst; the bench asserts this.
- upd_* is ignored when IFETCH_BTB_EN is undefined.

Optional Feature:
- Macro: IFETCH_BTB_EN.
- Defined:
  - Direct-mapped BTB of BTB_ENTRIES entries, indexed by pc[log2(BTB_ENTRIES)+1:2].
  - Each entry holds {valid, tag = pc[31:log2+2], target, 2-bit counter}.
  - Predict taken when tag hits and counter >= 2.
  - On upd_en: allocate on miss (counter = 2 if taken, else 1); on hit, saturate the counter up or down and overwrite the target.
  - BTB reads are combinational at request time; updates are written at the clock edge.
- Undefined: if_branch = 0, if_branch_addr = pc + 4, no BTB storage.

Decomposition:
- Shared package (ifetch_pkg):
  - RESET_PC default.
  - FSM state enum {REQ, WAIT, FULL}.
  - ADEF exception-bit position in the except_type vector.
  - Branch-update struct {pc, taken, target}.
- Sub-module: ifetch_btb (prediction lookup plus update port), instantiated only under IFETCH_BTB_EN.

Test Plan:
1. Reset, zero-wait bus, id_ready = 1 -> requests at 1c000000, 1c000004, 1c000008; if_pc follows in order with 2-cycle spacing and matching inst.
2. id_ready = 0 for 5 cycles after the first slot fills -> if_pc / if_inst held stable, no new inst_req; ready high -> next request at 1c000004.
3. redirect_en with redirect_pc = 1c000100 while in WAIT -> the returning data is dropped; next request addr = 1c000100; if_valid never shows the cancelled word.
4. redirect_pc = 1c000102 -> no inst_req; if_valid = 1, if_adef = 1, if_pc = 1c000102.
5. IFETCH_BTB_EN: upd_en twice at pc 1c000010 with taken and target 1c000040 -> the next fetch of 1c000010 gives if_branch = 1, if_branch_addr = 1c000040, next request 1c000040.
6. Redirect in the same cycle as data_ok and id_ready -> slot invalidated, data dropped, next request at redirect_pc.
